// File: rtl/uart_frame_deframer.sv
// Receive-side deframer for the "&&payload&&" UART string protocol: strips the
// delimiters, buffers the payload and holds it for a host reader until acknowledged.
module uart_frame_deframer #(
    parameter int MAX_LEN     = 128,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_vld,
    output logic             frame_valid,
    output logic [LEN_W-1:0] frame_len,
    input  logic             frame_ack,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic             overrun,
    output logic             busy,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [7:0]       rd_data
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SOF1    = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_AMP     = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;

    localparam logic [7:0]       AMP_CHAR  = 8'h26;
    localparam int               AW        = $clog2(MAX_LEN);
    localparam int               CNT_W     = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [LEN_W:0]   MAX_LEN_X = (LEN_W + 1)'(MAX_LEN);

    logic [7:0]       mem_q [MAX_LEN];
    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [AW-1:0]    pend_addr_q, pend_addr_d;
    logic [7:0]       pend_data_q, pend_data_d;
    logic             frame_valid_q, frame_valid_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;
    logic             frame_err_q, frame_err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;
    logic [7:0]       rd_data_q, rd_data_d;

    logic             is_amp_s;
    logic [LEN_W:0]   wr_ptr_x_s;
    logic [LEN_W-1:0] wr_ptr_inc_s;
    logic             abort_s;
    logic [1:0]       abort_code_s;
    logic             wr_en_s;
    logic [AW-1:0]    wr_addr_s;
    logic [7:0]       wr_data_s;

    assign is_amp_s     = (rx_data == AMP_CHAR);
    assign wr_ptr_x_s   = {1'b0, wr_ptr_q};
    assign wr_ptr_inc_s = wr_ptr_q + {{(LEN_W-1){1'b0}}, 1'b1};

    // Frame FSM, buffer write port and inter-byte timeout.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        pend_d       = 1'b0;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        frame_len_d  = frame_len_q;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
        overrun_d    = overrun_q;
        abort_s      = 1'b0;
        abort_code_s = 2'b00;
        // The deferred second byte of an escaped '&' lands here; rx_vld spacing keeps the port free.
        wr_en_s      = pend_q;
        wr_addr_s    = pend_addr_q;
        wr_data_s    = pend_data_q;

        case (state_q)
            S_IDLE: begin
                if (rx_vld && is_amp_s) state_d = S_SOF1;
                else                    state_d = S_IDLE;
            end
            S_SOF1: begin
                if (rx_vld && is_amp_s) begin
                    state_d  = S_PAYLOAD;
                    wr_ptr_d = {LEN_W{1'b0}};
                end else if (rx_vld) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SOF1;
                end
            end
            S_PAYLOAD: begin
                if (rx_vld && is_amp_s) begin
                    state_d = S_AMP;
                end else if (rx_vld && (wr_ptr_x_s == MAX_LEN_X)) begin
                    abort_s      = 1'b1;
                    abort_code_s = 2'b01;
                end else if (rx_vld) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = wr_ptr_q[AW-1:0];
                    wr_data_s = rx_data;
                    wr_ptr_d  = wr_ptr_inc_s;
                end else begin
                    state_d = S_PAYLOAD;
                end
            end
            S_AMP: begin
                if (rx_vld && is_amp_s) begin
                    state_d     = S_HOLD;
                    frame_len_d = wr_ptr_q;
                end else if (rx_vld && ((wr_ptr_x_s + (LEN_W + 1)'(2)) > MAX_LEN_X)) begin
                    abort_s      = 1'b1;
                    abort_code_s = 2'b01;
                end else if (rx_vld) begin
                    wr_en_s     = 1'b1;
                    wr_addr_s   = wr_ptr_q[AW-1:0];
                    wr_data_s   = AMP_CHAR;
                    pend_d      = 1'b1;
                    pend_addr_d = wr_ptr_inc_s[AW-1:0];
                    pend_data_d = rx_data;
                    wr_ptr_d    = wr_ptr_q + {{(LEN_W-2){1'b0}}, 2'd2};
                    state_d     = S_PAYLOAD;
                end else begin
                    state_d = S_AMP;
                end
            end
            S_HOLD: begin
                if (frame_ack) begin
                    overrun_d = 1'b0;
                    if (rx_vld && is_amp_s) state_d = S_SOF1;
                    else                    state_d = S_IDLE;
                end else if (rx_vld) begin
                    overrun_d = 1'b1;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_q == S_SOF1) || (state_q == S_PAYLOAD) || (state_q == S_AMP)) begin
            if (rx_vld) begin
                cnt_d = {CNT_W{1'b0}};
            end else if (cnt_q == TO_LAST) begin
                cnt_d        = {CNT_W{1'b0}};
                abort_s      = 1'b1;
                abort_code_s = 2'b10;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end

        if (abort_s) begin
            state_d     = S_IDLE;
            wr_ptr_d    = {LEN_W{1'b0}};
            frame_err_d = 1'b1;
            err_code_d  = abort_code_s;
        end else begin
            frame_err_d = 1'b0;
        end

        frame_valid_d = (state_d == S_HOLD);
        busy_d        = (state_d == S_SOF1) || (state_d == S_PAYLOAD) || (state_d == S_AMP);
    end

    // Registered read port; out-of-range addresses read as zero.
    always_comb begin
        rd_data_d = 8'h00;
        if ({1'b0, rd_addr} < MAX_LEN_X) rd_data_d = mem_q[rd_addr[AW-1:0]];
        else                             rd_data_d = 8'h00;
    end

    // Payload buffer storage (not reset).
    always_ff @(posedge sys_clk) begin
        if (wr_en_s) mem_q[wr_addr_s] <= wr_data_s;
    end

    // State and output registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= {LEN_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            pend_q        <= 1'b0;
            pend_addr_q   <= {AW{1'b0}};
            pend_data_q   <= 8'h00;
            frame_valid_q <= 1'b0;
            frame_len_q   <= {LEN_W{1'b0}};
            frame_err_q   <= 1'b0;
            err_code_q    <= 2'b00;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
            rd_data_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            pend_addr_q   <= pend_addr_d;
            pend_data_q   <= pend_data_d;
            frame_valid_q <= frame_valid_d;
            frame_len_q   <= frame_len_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_len   = frame_len_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;
    assign rd_data     = rd_data_q;

endmodule
